ram_bist_ctrl: RTL
==================

Name: ram_bist_ctrl

Overview:
Synthesizable initiator for the DataRAM port (Addr, DataIn, MemWR, DataOut). On Start it writes a deterministic pattern to a contiguous address range, reads the range back, and compares each word. It reports pass/fail, the mismatch count and the first failing address. It sits beside DataRAM and is muxed onto its port during power-on self-test.

Parameters:
N, 5, address width; matches DataRAM n
M, 32, data width; matches DataRAM m
LAST_ADDR, 2**N-1, highest address tested; the range is 0..LAST_ADDR
STEP, 4, pattern multiplier
SEED, 0, pattern offset

Ports:
Clk  input  1  rising-edge clock, shared with DataRAM
Reset  input  1  asynchronous, active-high reset
Start  input  1  level, sampled on the rising edge; begins a test run
Addr  output  N  RAM address
DataIn  output  M  RAM write data
MemWR  output  1  RAM write enable, 1 = write
DataOut  input  M  RAM read data; combinational from Addr (DataRAM read is asynchronous)
Busy  output  1  high in WRITE and READ
Done  output  1  high in DONE
Pass  output  1  valid when Done; 1 = zero mismatches
ErrCount  output  N+1  mismatch count, saturating
FailAddr  output  N  address of the first mismatch; 0 if none

Behaviour:
- pattern(a) = (a*STEP + SEED) truncated to M bits; computed in M-bit arithmetic, with a zero-extended.
- Addr, DataIn and MemWR come straight from registers (state, cnt). Combinational glitches on MemWR are forbidden.
- Reset asserted, asynchronously: state=IDLE, cnt=0, Addr=0, DataIn=0, MemWR=0, Busy=0, Done=0, Pass=0, ErrCount=0, FailAddr=0. Deasserting Reset mid-run leaves the block in IDLE; the run is not resumed.
- FSM states: IDLE, WRITE, READ, DONE.
- IDLE:
  - MemWR=0.
  - Start=1 at an edge -> WRITE; cnt=0; ErrCount, FailAddr and the first-fail flag cleared.
- WRITE:
  - MemWR=1, Addr=cnt, DataIn=pattern(cnt). The RAM captures the word at the next edge.
  - At each edge: if cnt==LAST_ADDR -> READ with cnt=0; else cnt+1.
  - Exactly LAST_ADDR+1 write cycles per run.
- READ:
  - MemWR=0, Addr=cnt, DataIn held at the last written value.
  - At each edge: if DataOut != pattern(cnt), ErrCount increments, saturating at all-ones. On the first mismatch of the run, FailAddr=cnt.
  - If cnt==LAST_ADDR -> DONE (the compare at that edge still counts); else cnt+1.
- DONE:
  - Done=1, MemWR=0, Pass=(ErrCount==0).
  - Results hold until Start=1 at an edge, which restarts directly into WRITE with results cleared (same as from IDLE).
- Start is ignored in WRITE and READ; it is not queued.
- Latency: Start sampled at edge E0 -> writes at E1..E(L+1) -> compares at E(L+2)..E(2L+2) -> Done high after E(2L+2), where L=LAST_ADDR. For L=9, Done rises 20 cycles after E0.
- Wrap: cnt never exceeds LAST_ADDR. For LAST_ADDR=2**N-1, cnt must not overflow before the compare.
- Edge case LAST_ADDR=0: one write cycle, one read cycle, then DONE.
- Busy and Done are never high together. Pass is 0 whenever Done=0.

Test Plan:
- Fault-free run: behavioural DataRAM, N=5, M=32, LAST_ADDR=9, STEP=4, SEED=0, Start pulsed one cycle -> MemWR=1 for exactly 10 cycles with Addr 0..9 and DataIn 0,4,...,36. Then 10 read cycles with MemWR=0. Done rises 20 cycles after the Start edge, with Pass=1, ErrCount=0, FailAddr=0. RAM[7] reads 28.
- Stuck-at fault: bench forces RAM word 3 bit0 = 1 on read -> Pass=0, ErrCount=1, FailAddr=3. Adding a second fault at word 8 -> ErrCount=2, FailAddr still 3.
- Full range with saturation: LAST_ADDR=31, RAM model returning 0xFFFFFFFF for all reads -> 32 writes then 32 reads, ErrCount=32 (6-bit, not saturated), FailAddr=0, Pass=0. With N=2 and LAST_ADDR=3 forcing all errors -> ErrCount=4.
- Reset mid-operation: Reset asserted asynchronously between edges during WRITE at cnt=5 -> MemWR drops to 0 before the next edge and every output is at its reset value. Start after release runs a full 20-cycle test.
- Start handling: Start held high during a run -> no restart, and Done still comes 20 cycles after the first edge. Start pulsed in DONE with SEED=1 -> results cleared on that edge, DataIn sequence 1,5,...,37, and Pass=1.
- LAST_ADDR=0: Start -> one write to Addr 0 with DataIn=SEED, one read, Done 2 cycles after the Start edge.

Source files
------------

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: power-on self-test initiator for the DataRAM port.
// Writes pattern(a) = a*STEP + SEED over 0..LAST_ADDR, reads it back and
// reports pass/fail, a saturating mismatch count and the first failing address.
module ram_bist_ctrl #(
  parameter int unsigned N         = 5,
  parameter int unsigned M         = 32,
  parameter int unsigned LAST_ADDR = 2**N - 1,
  parameter int unsigned STEP      = 4,
  parameter int unsigned SEED      = 0
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  output logic [N-1:0] Addr,
  output logic [M-1:0] DataIn,
  output logic         MemWR,
  input  logic [M-1:0] DataOut,
  output logic         Busy,
  output logic         Done,
  output logic         Pass,
  output logic [N:0]   ErrCount,
  output logic [N-1:0] FailAddr
);

  localparam int unsigned ERR_W = N + 1;
  localparam logic [N-1:0] LAST = N'(LAST_ADDR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } stateT;

  stateT state, stateNext;

  logic [N-1:0]     cnt, cntNext;
  logic [M-1:0]     dataInNext;
  logic [ERR_W-1:0] errNext;
  logic [N-1:0]     failNext;
  logic             firstFail, firstNext;
  logic             memWrNext, busyNext, doneNext, passNext;
  logic             atLast, mismatch;

  // Test pattern in M-bit arithmetic with the address zero-extended.
  function automatic logic [M-1:0] pattern(input logic [N-1:0] a);
    return M'(a) * M'(STEP) + M'(SEED);
  endfunction

  assign Addr     = cnt;
  assign atLast   = (cnt == LAST);
  assign mismatch = (DataOut != pattern(cnt));

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic; Start only matters in IDLE and DONE.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (Start)  stateNext = WRITE;
      WRITE:   if (atLast) stateNext = READ;
      READ:    if (atLast) stateNext = DONE;
      DONE:    if (Start)  stateNext = WRITE;
      default: stateNext = IDLE;
    endcase
  end

  // Next values for the counter, result registers and the RAM-facing outputs.
  always_comb begin
    cntNext    = cnt;
    dataInNext = DataIn;
    errNext    = ErrCount;
    failNext   = FailAddr;
    firstNext  = firstFail;
    case (state)
      IDLE, DONE: begin
        if (Start) begin
          cntNext   = '0;
          errNext   = '0;
          failNext  = '0;
          firstNext = 1'b0;
        end
      end
      WRITE: cntNext = atLast ? '0 : cnt + N'(1);
      READ: begin
        if (mismatch) begin
          if (ErrCount != '1) errNext = ErrCount + ERR_W'(1);
          if (!firstFail) begin
            failNext  = cnt;
            firstNext = 1'b1;
          end
        end
        cntNext = atLast ? cnt : cnt + N'(1);
      end
      default: ;
    endcase
    if (stateNext == WRITE) dataInNext = pattern(cntNext);
    memWrNext = (stateNext == WRITE);
    busyNext  = (stateNext == WRITE) || (stateNext == READ);
    doneNext  = (stateNext == DONE);
    passNext  = doneNext && (errNext == '0);
  end

  // Output and datapath registers; MemWR is a flop so it cannot glitch.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt       <= '0;
      DataIn    <= '0;
      MemWR     <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Pass      <= 1'b0;
      ErrCount  <= '0;
      FailAddr  <= '0;
      firstFail <= 1'b0;
    end else begin
      cnt       <= cntNext;
      DataIn    <= dataInNext;
      MemWR     <= memWrNext;
      Busy      <= busyNext;
      Done      <= doneNext;
      Pass      <= passNext;
      ErrCount  <= errNext;
      FailAddr  <= failNext;
      firstFail <= firstNext;
    end
  end

endmodule
